// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: FSM state
// encoding, opcode values and the mux-select / ALUOp encodings driven
// towards the datapath and the ALU decoder.
// Optional feature macro: CTRL_BNE_EN (adds bne to the branch state).
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // beq is always legal; bne only when the optional comparison is built in.
    function automatic logic branch_legal(input logic [2:0] funct3);
`ifdef CTRL_BNE_EN
        return (funct3 == 3'b000) || (funct3 == 3'b001);
`else
        return (funct3 == 3'b000);
`endif
    endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Combinational opcode -> immediate-format decoder. R-type and unknown
// opcodes carry no immediate and fall back to the I encoding.
module imm_src_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // Pick the immediate layout the sign-extender should assemble.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BRANCH:   imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RISC-V core. Sequences fetch, decode,
// execute and writeback, drives the datapath selects/enables and the ALUOp
// consumed by the ALU decoder, waits on mem_ready for memory accesses and
// counts retired instructions.
// Optional feature macro: CTRL_BNE_EN (bne handled in the branch state).
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t state;
    state_t next_state;

    logic pc_write_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;

    imm_src_dec u_imm_src_dec (
        .op      (op),
        .imm_src (ImmSrc)
    );

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state selection from the current state, opcode and handshake.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BRANCH:    next_state = S_BRANCH;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = branch_legal(funct3) ? S_FETCH : S_ILLEGAL;
            S_JAL:      next_state = S_ALUWB;
            S_ILLEGAL:  next_state = S_ILLEGAL;
            default:    next_state = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the state; only the fetch/memory
    // handshake and the branch condition look at inputs.
    always_comb begin
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ALUOp         = ALU_OP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_OP_FUNCT;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALU_OP_SUB;
                // An unsupported funct3 must not redirect the PC on its way to ILLEGAL.
                if (funct3 == 3'b000)
                    pc_write_raw = zero;
`ifdef CTRL_BNE_EN
                else if (funct3 == 3'b001)
                    pc_write_raw = ~zero;
`endif
            end
            S_JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset blocks every architectural write in the cycle it is asserted.
    always_comb begin
        PCWrite  = pc_write_raw  & ~reset;
        MemWrite = mem_write_raw & ~reset;
        IRWrite  = ir_write_raw  & ~reset;
        RegWrite = reg_write_raw & ~reset;
        illegal  = (state == S_ILLEGAL);
    end

    // Retired-instruction counter: one tick each time an instruction hands back to FETCH.
    always_ff @(posedge clk) begin
        if (reset)
            instret <= '0;
        else if ((next_state == S_FETCH) && (state != S_FETCH))
            instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (CNT_W=4 so the counter wraps).
// Stimulus computes each instruction's expected control sequence from the
// per-phase control table and pushes one record per cycle; an independent
// monitor pops and compares at every falling edge.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [1:0] imm;
        logic       ill;
        logic [3:0] ret;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [CNT_W-1:0] instret;

    exp_t  exp_q[$];
    string name_q[$];
    int    assertions = 0;
    int    failures   = 0;
    logic [3:0] model_ret = 4'd0;
    logic  bne_en;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (pc_write),
        .AdrSrc    (adr_src),
        .MemWrite  (mem_write),
        .IRWrite   (ir_write),
        .RegWrite  (reg_write),
        .ResultSrc (result_src),
        .ALUSrcA   (alu_src_a),
        .ALUSrcB   (alu_src_b),
        .ALUOp     (alu_op),
        .ImmSrc    (imm_src),
        .illegal   (illegal),
        .instret   (instret)
    );

    // Immediate format implied by the opcode.
    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            SW:      return 2'b01;
            BR:      return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Compare one cycle of DUT outputs against the popped expectation.
    task automatic checkOutput(input exp_t e, input string nm);
        exp_t got;
        got = '{pcw: pc_write, adr: adr_src, memw: mem_write, irw: ir_write,
                regw: reg_write, res: result_src, a: alu_src_a, b: alu_src_b,
                aop: alu_op, imm: imm_src, ill: illegal, ret: instret};
        assertions++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL %s @%0t: got %b expected %b", nm, $time, got, e);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is checked.
    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), name_q.pop_front());
    end

    // Drive one cycle of inputs, record what the controller must show, advance.
    task automatic emit(input string nm, input logic rst, input logic mr, input logic zr,
                        input logic pcw, input logic adr, input logic memw, input logic irw,
                        input logic regw, input logic [1:0] res, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] aop, input logic ill);
        exp_t e;
        reset = rst; mem_ready = mr; zero = zr;
        e = '{pcw: pcw, adr: adr, memw: memw, irw: irw, regw: regw, res: res, a: a,
              b: b, aop: aop, imm: imm_of(op), ill: ill, ret: model_ret};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic retire();
        model_ret = model_ret + 4'd1;
    endtask

    task automatic fetch_decode(input int fw);
        repeat (fw) emit("fetch_wait", 0, 0, rb(), 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
        emit("fetch",  0, 1, rb(), 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
        emit("decode", 0, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
    endtask

    // Sit in the trap for a while, then clear it with a reset cycle.
    task automatic illegal_tail();
        repeat (10) emit("illegal", 0, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        emit("illegal_reset", 1, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        model_ret = 4'd0;
    endtask

    // One complete instruction with fw fetch waits and mw memory waits.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f, input logic z,
                                 input int fw, input int mw);
        logic legal;
        logic pc_exp;
        op = o; funct3 = f;
        fetch_decode(fw);
        case (o)
            LW: begin
                emit("memadr", 0, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
                repeat (mw) emit("memread_wait", 0, 0, rb(), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                emit("memread", 0, 1, rb(), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                emit("memwb", 0, rb(), rb(), 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
                retire();
            end
            SW: begin
                emit("memadr", 0, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
                repeat (mw) emit("memwrite_wait", 0, 0, rb(), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                emit("memwrite", 0, 1, rb(), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                retire();
            end
            RT, IT: begin
                emit("exec", 0, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00, 2'b10, 0);
                emit("aluwb", 0, rb(), rb(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                retire();
            end
            BR: begin
                legal  = (f == 3'b000) || (bne_en && f == 3'b001);
                pc_exp = !legal ? 1'b0 : (f == 3'b000) ? z : ~z;
                emit("branch", 0, rb(), z, pc_exp, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
                if (legal) retire();
                else       illegal_tail();
            end
            JAL: begin
                emit("jal", 0, rb(), rb(), 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
                emit("aluwb", 0, rb(), rb(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                retire();
            end
            default: illegal_tail();
        endcase
    endtask

    // Abort a memory instruction with reset, either in MEMADR or inside MEMWRITE.
    task automatic applyAbort(input logic [6:0] o, input logic at_memwrite);
        op = o; funct3 = 3'b010;
        fetch_decode(0);
        if (at_memwrite) begin
            emit("memadr", 0, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
            emit("memwrite_reset", 1, 1, rb(), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        end else begin
            emit("memadr_reset", 1, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        end
        model_ret = 4'd0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef CTRL_BNE_EN
        bne_en = 1'b1;
`else
        bne_en = 1'b0;
`endif
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = RT; funct3 = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        // Still in reset: FETCH selects visible, IRWrite/PCWrite held off.
        emit("reset_fetch", 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);

        applyStimulus(RT, 3'b000, 0, 0, 0);
        applyStimulus(LW, 3'b010, 0, 0, 3);
        applyStimulus(SW, 3'b010, 0, 1, 2);
        applyStimulus(BR, 3'b000, 1, 0, 0);
        applyStimulus(BR, 3'b000, 0, 0, 0);
        applyStimulus(IT, 3'b000, 0, 0, 0);
        applyStimulus(7'b1111111, 3'b000, 0, 0, 0);
        applyStimulus(BR, 3'b001, 0, 0, 0);
        applyStimulus(BR, 3'b001, 1, 0, 0);
        applyStimulus(BR, 3'b101, 1, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(JAL, 3'($urandom), 0, 0, 0);
        applyAbort(LW, 1'b0);
        applyAbort(SW, 1'b1);

        for (int i = 0; i < 60; i++) begin
            int sel;
            logic [6:0] o;
            logic [2:0] f;
            sel = $urandom_range(0, 12);
            case (sel)
                0, 1:    o = LW;
                2, 3:    o = SW;
                4, 5:    o = RT;
                6, 7:    o = IT;
                8, 9:    o = BR;
                10, 11:  o = JAL;
                default: o = 7'($urandom);
            endcase
            f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : {2'b00, rb()};
            applyStimulus(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RISC-V core. It is the producer side of the aluOp interface that the ALU decoder consumes. It sequences fetch/decode/execute/writeback over several cycles, driving datapath mux selects, write enables and the 2-bit ALUOp. It also handles memory wait states through a ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  7  instr[6:0]
funct3  input  3  instr[14:12]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  0=PC, 1=ALUOut as memory address
MemWrite  output  1  data memory write request
IRWrite  output  1  instruction/OldPC register enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  output  2  00=rs2, 01=imm, 10=constant 4
ALUOp  output  2  00=add, 01=sub (branch), 10=funct-decoded
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J (combinational from op; 00 for R/unknown)
illegal  output  1  sticky illegal-instruction flag
instret  output  CNT_W  retired-instruction count

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset: state=FETCH, instret=0, illegal=0. While reset=1, PCWrite/IRWrite/MemWrite/RegWrite are forced 0. Reset mid-instruction aborts the instruction with no partial writes after that edge.
- Control outputs are Moore (decoded from state) except PCWrite in BRANCH and the mem_ready gating below. Any field not listed = 0.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Goes to DECODE when mem_ready, else stays.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
  - Next state by op: lw/sw->MEMADR, R->EXECR, I->EXECI, branch->BRANCH, jal->JAL, other->ILLEGAL.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, else stays.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready. Goes to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero (beq).
  - funct3≠000 goes to ILLEGAL (see option). Otherwise goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Goes to ALUWB (writes PC+4 to rd).
- ILLEGAL: all enables 0, illegal=1. Stays until reset.
- instret increments by 1 on every transition into FETCH from a non-FETCH state. Wraps modulo 2^CNT_W. Not incremented on reset.
- Latency without waits: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles.

Optional Feature:
CTRL_BNE_EN
- Defined: funct3=001 in BRANCH is legal, with PCWrite=~zero. Only funct3 not in {000,001} goes to ILLEGAL.
- Undefined: only funct3=000 is legal. 001 goes to ILLEGAL.

Decomposition:
- ctrl_pkg holds:
  - state enum (FETCH..ILLEGAL)
  - opcode localparams
  - ALUOp encodings (ADD=00, SUB=01, FUNCT=10)
  - ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings
- One natural sub-module: imm_src_dec, a combinational op->ImmSrc decoder. The FSM, output decode and counter stay in multicycle_ctrl.

Test Plan:
- Reset held 2 cycles, mem_ready=1, op=0110011 -> FETCH, DECODE, EXECR(ALUOp=10), ALUWB(RegWrite=1), FETCH; instret=1.
- lw op=0000011 with mem_ready=0 for 3 cycles in MEMREAD -> state holds 3 extra cycles with AdrSrc=1, RegWrite=0; MEMWB then fires; instret increments once.
- sw with mem_ready low 2 cycles -> MemWrite=1 on all 3 MEMWRITE cycles, falls to 0 in FETCH.
- Branch funct3=000: zero=1 -> PCWrite=1 in BRANCH, ALUOp=01; zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- op=1111111 -> ILLEGAL, illegal=1, all enables 0 for 10 cycles; reset -> illegal=0, FETCH. Branch funct3=001 -> ILLEGAL without CTRL_BNE_EN, PCWrite=~zero with it.
- CNT_W=4: run 16 jal instructions -> instret wraps 15->0. Reset asserted in MEMADR -> next cycle FETCH, no MemWrite/RegWrite.
